// File: rtl/effect_sequencer_if.sv
// Key requests in, effect enables and status out.
// Master drives keys and vsync; slave is the sequencer.
interface effect_sequencer_if #(
  parameter int NUM_FX = 4,
  parameter int IDX_W  = $clog2(NUM_FX + 1)
);
  logic              vsync;
  logic              key_next;
  logic              key_prev;
  logic              key_auto;
  logic [NUM_FX-1:0] fx_en;
  logic [IDX_W-1:0]  mode_idx;
  logic              auto_on;
  logic              pending;

  modport master (
    output vsync, key_next, key_prev, key_auto,
    input  fx_en, mode_idx, auto_on, pending
  );

  modport slave (
    input  vsync, key_next, key_prev, key_auto,
    output fx_en, mode_idx, auto_on, pending
  );
endinterface

// File: rtl/effect_sequencer.sv
// Frame-synchronous effect selector: keys retarget the mode,
// enables only switch on a vsync rising edge.
module effect_sequencer #(
  parameter int NUM_FX       = 4,
  parameter int DWELL_FRAMES = 120
) (
  input logic clk,
  input logic rst,
  effect_sequencer_if.slave seq
);
  localparam int IDX_W = $clog2(NUM_FX + 1);
  localparam int CNT_W = $clog2(DWELL_FRAMES + 1);
  localparam logic [IDX_W-1:0] MAX_IDX  = IDX_W'(NUM_FX);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL_FRAMES - 1);

  typedef enum logic {STEADY, PENDING} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cur_q, cur_d;
  logic [IDX_W-1:0]  tgt_q, tgt_d;
  logic [NUM_FX-1:0] fx_q, fx_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d;
  logic              auto_q, auto_d;
  logic              vs_q;

  logic fs, k_next, k_prev, k_man;
  logic sel_auto, sel_man, sel_commit, sel_dwell;

  function automatic logic [IDX_W-1:0] inc(input logic [IDX_W-1:0] v);
    return (v == MAX_IDX) ? '0 : v + IDX_W'(1);
  endfunction

  function automatic logic [IDX_W-1:0] dec(input logic [IDX_W-1:0] v);
    return (v == '0) ? MAX_IDX : v - IDX_W'(1);
  endfunction

  assign fs     = seq.vsync & ~vs_q;
  assign k_next = seq.key_next & ~seq.key_prev & ~seq.key_auto;
  assign k_prev = seq.key_prev & ~seq.key_next & ~seq.key_auto;
  assign k_man  = k_next | k_prev;

  // Exclusive event selects; key_auto outranks manual keys
  assign sel_auto   = seq.key_auto;
  assign sel_man    = k_man;
  assign sel_commit = (state_q == PENDING) & fs & ~seq.key_auto & ~k_man;
  assign sel_dwell  = (state_q == STEADY) & auto_q & fs
                    & ~seq.key_auto & ~k_man;

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    dwell_d = dwell_q;
    auto_d  = auto_q;
    unique case (1'b1)
      sel_auto: begin
        auto_d  = ~auto_q;
        dwell_d = '0;
        tgt_d   = cur_q;
        state_d = STEADY;
      end
      sel_man: begin
        if (state_q == PENDING && fs) cur_d = tgt_q;
        auto_d  = 1'b0;
        dwell_d = '0;
        tgt_d   = k_next ? inc(tgt_q) : dec(tgt_q);
        state_d = PENDING;
      end
      sel_commit: begin
        cur_d   = tgt_q;
        state_d = STEADY;
      end
      sel_dwell: begin
        if (dwell_q == LAST_CNT) begin
          cur_d   = inc(cur_q);
          tgt_d   = inc(cur_q);
          dwell_d = '0;
        end else begin
          dwell_d = dwell_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
    for (int i = 0; i < NUM_FX; i++)
      fx_d[i] = (cur_d == IDX_W'(i + 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= STEADY;
      cur_q   <= '0;
      tgt_q   <= '0;
      fx_q    <= '0;
      dwell_q <= '0;
      auto_q  <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      fx_q    <= fx_d;
      dwell_q <= dwell_d;
      auto_q  <= auto_d;
      vs_q    <= seq.vsync;
    end
  end

  assign seq.fx_en    = fx_q;
  assign seq.mode_idx = cur_q;
  assign seq.auto_on  = auto_q;
  assign seq.pending  = (state_q == PENDING);
endmodule

// File: tb/tb_effect_sequencer.sv
// Scoreboard bench for effect_sequencer, NUM_FX=4,
// DWELL_FRAMES=3; expected outputs queued per step.
module tb_effect_sequencer;
  localparam int NUM_FX = 4;
  localparam int IDX_W  = $clog2(NUM_FX + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  effect_sequencer_if #(.NUM_FX(NUM_FX)) sif ();

  effect_sequencer #(
    .NUM_FX(NUM_FX),
    .DWELL_FRAMES(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .seq(sif.slave)
  );

  typedef struct {
    logic [IDX_W-1:0] m;
    logic             p;
    logic             a;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NUM_FX-1:0] fx_of(input logic [IDX_W-1:0] m);
    logic [NUM_FX-1:0] one;
    one = 1;
    return (m == 0) ? '0 : (one << (m - 1));
  endfunction

  task automatic step(input logic r, input logic vs, input logic kn,
                      input logic kp, input logic ka);
    @(negedge clk);
    rst          = r;
    sif.vsync    = vs;
    sif.key_next = kn;
    sif.key_prev = kp;
    sif.key_auto = ka;
    @(posedge clk);
    #1;
  endtask

  task automatic stepx(input string tag, input logic r, input logic vs,
                       input logic kn, input logic kp, input logic ka,
                       input int m, input logic p, input logic a);
    exp_t e;
    e.m = IDX_W'(m);
    e.p = p;
    e.a = a;
    sb.push_back(e);
    step(r, vs, kn, kp, ka);
    if (sb.size() == 0) begin
      chk({tag, "_sb"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_mode"}, 32'(sif.mode_idx), 32'(e.m));
      chk({tag, "_fx"},   32'(sif.fx_en),    32'(fx_of(e.m)));
      chk({tag, "_pend"}, 32'(sif.pending),  32'(e.p));
      chk({tag, "_auto"}, 32'(sif.auto_on),  32'(e.a));
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("onehot0", 32'($onehot0(sif.fx_en)), 1);
      chk("fx_vs_mode", 32'(sif.fx_en), 32'(fx_of(sif.mode_idx)));
    end
  end

  initial begin
    sif.vsync    = 1'b0;
    sif.key_next = 1'b0;
    sif.key_prev = 1'b0;
    sif.key_auto = 1'b0;

    step(1, 0, 0, 0, 0);
    stepx("reset", 1, 0, 0, 0, 0, 0, 0, 0);
    mon_en = 1'b1;

    // basic next then frame start
    stepx("t1_key",    0, 0, 1, 0, 0, 0, 1, 0);
    stepx("t1_hold",   0, 0, 0, 0, 0, 0, 1, 0);
    stepx("t1_commit", 0, 1, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);

    // up to 4, wrap to 0, prev wraps to 4
    step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    stepx("t2_acc",  0, 0, 1, 0, 0, 1, 1, 0);
    stepx("t2_m4",   0, 1, 0, 0, 0, 4, 0, 0);
    step(0, 0, 0, 0, 0);
    stepx("t2_nk",   0, 0, 1, 0, 0, 4, 1, 0);
    stepx("t2_m0",   0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    stepx("t2_pk",   0, 0, 0, 1, 0, 0, 1, 0);
    stepx("t2_wrap", 0, 1, 0, 0, 0, 4, 0, 0);
    step(0, 0, 0, 0, 0);

    // simultaneous keys, key in commit cycle
    stepx("t3_both", 0, 0, 1, 1, 0, 4, 0, 0);
    stepx("t3_nk",   0, 0, 1, 0, 0, 4, 1, 0);
    stepx("t3_m0",   0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    stepx("t3_k1",   0, 0, 1, 0, 0, 0, 1, 0);
    stepx("t3_fsk",  0, 1, 1, 0, 0, 1, 1, 0);
    stepx("t3_wait", 0, 0, 0, 0, 0, 1, 1, 0);
    stepx("t3_m2",   0, 1, 0, 0, 0, 2, 0, 0);
    step(0, 0, 0, 0, 0);

    // auto-cycle every 3 frames
    stepx("t4_on", 0, 0, 0, 0, 1, 2, 0, 1);
    begin
      int exp_m[7] = '{2, 2, 3, 3, 3, 4, 4};
      for (int f = 0; f < 7; f++) begin
        stepx($sformatf("t4_f%0d", f + 1), 0, 1, 0, 0, 0,
              exp_m[f], 0, 1);
        step(0, 0, 0, 0, 0);
      end
    end
    stepx("t4_prev",  0, 0, 0, 1, 0, 4, 1, 0);
    stepx("t4_m3",    0, 1, 0, 0, 0, 3, 0, 0);
    step(0, 0, 0, 0, 0);
    stepx("t4_awins", 0, 0, 1, 0, 1, 3, 0, 1);
    stepx("t4_aoff",  0, 0, 0, 0, 1, 3, 0, 0);
    stepx("t4_pk",    0, 0, 1, 0, 0, 3, 1, 0);
    stepx("t4_cancel",0, 0, 0, 0, 1, 3, 0, 1);
    stepx("t4_nocm",  0, 1, 0, 0, 0, 3, 0, 1);
    step(0, 0, 0, 0, 0);
    stepx("t4_off2",  0, 0, 0, 0, 1, 3, 0, 0);

    // reset discards pending request
    stepx("t5_key", 0, 0, 1, 0, 0, 3, 1, 0);
    stepx("t5_rst", 1, 0, 0, 0, 0, 0, 0, 0);
    stepx("t5_fs",  0, 1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    // long vsync high gives a single frame start
    stepx("t6_key", 0, 0, 1, 0, 0, 0, 1, 0);
    stepx("t6_fs",  0, 1, 0, 0, 0, 1, 0, 0);
    for (int c = 2; c <= 10; c++)
      step(0, 1, (c == 5), 0, 0);
    stepx("t6_hi",  0, 1, 0, 0, 0, 1, 1, 0);
    stepx("t6_lo",  0, 0, 0, 0, 0, 1, 1, 0);
    stepx("t6_fs2", 0, 1, 0, 0, 0, 2, 0, 0);
    step(0, 0, 0, 0, 0);

    mon_en = 1'b0;
    if (sb.size() != 0) chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
